fetch_redirect_ctrl: RTL and testbench
======================================

# fetch_redirect_ctrl

Controls the fetch stage. It owns the PC register and the IF/ID prediction latches, and it resolves branches that reach decode against the dynamic branch predictor's prediction. On a misprediction it flushes the wrong-path slot and redirects fetch, then drives the BHT/BTB update strobes. It sits between the dynamic branch predictor (which supplies `pred_taken`/`pred_target` for `pc_curr`), the hazard unit (`stall_in`) and decode (branch resolution, HLT detection).

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset.
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall_in  in  1  hazard stall; holds PC and IF/ID.
- halt_in  in  1  decode sees HLT in the IF/ID slot.
- pred_taken  in  1  predictor's taken bit for `pc_curr`.
- pred_target  in  16  predictor's target for `pc_curr`.
- id_is_branch  in  1  IF/ID instruction is a branch.
- id_actual_taken  in  1  resolved branch direction.
- id_actual_target  in  16  resolved branch target.
- pc_curr  out  16  current fetch PC.
- if_id_pc  out  16  PC of the instruction in IF/ID.
- if_id_valid  out  1  IF/ID holds a live instruction.
- if_id_pred_taken  out  1  prediction latched with IF/ID.
- if_id_pred_target  out  16  target latched with IF/ID.
- branch_mispredicted  out  1  combinational misprediction strobe.
- flush_if_id  out  1  equals `branch_mispredicted`.
- upd_en  out  1  BHT update strobe.
- upd_taken  out  1  direction to train.
- upd_pc  out  4  predictor index, `if_id_pc[3:0]`.
- btb_wen  out  1  BTB write strobe; data is `id_actual_target`.
- halted  out  1  FSM is in HALT.
- branch_cnt  out  16  resolved branches, saturating.
- mispred_cnt  out  16  mispredictions, saturating.

## Operation
- `resolve = if_id_valid & id_is_branch & ~stall_in`.
- `branch_mispredicted = resolve & ((if_id_pred_taken != id_actual_taken) | (if_id_pred_taken & id_actual_taken & (if_id_pred_target != id_actual_target)))`.
- `redirect_pc = id_actual_taken ? id_actual_target : if_id_pc + 2`.
- Next-PC priority, highest first:
  - rst → RESET_PC
  - HALT state → hold
  - mispredict → `redirect_pc`
  - `stall_in` → hold
  - `pred_taken` → `pred_target`
  - otherwise → `pc_curr + 2`
- All PC arithmetic is mod 2^16; 16'hFFFE + 2 wraps to 16'h0000.
- IF/ID load rules:
  - Mispredict: load `valid=0` (squash the wrong-path instruction).
  - Stall: hold.
  - Otherwise: load `{pc_curr, pred_taken, pred_target}` with `valid=1`, except `valid=0` in BOOT and HALT.
- Predictor update:
  - `upd_en = resolve`.
  - `upd_taken = id_actual_taken`.
  - `btb_wen = branch_mispredicted & id_actual_taken`.
- `halt_in` is honored only when `if_id_valid & ~stall_in & ~id_is_branch`. `halt_in` together with `id_is_branch` is illegal; the branch path wins.
- Counters:
  - `branch_cnt` increments on `resolve`.
  - `mispred_cnt` increments on `branch_mispredicted`.
  - Both saturate at 16'hFFFF.
- FSM states:
  - BOOT: first cycle after reset; `if_id_valid` stays 0. Always goes to RUN.
  - RUN: on mispredict → RECOVER; on honored halt → HALT; else stay.
  - RECOVER: the bubble cycle; `if_id_valid` = 0, `resolve` = 0. Goes to RUN, or stays in RECOVER while `stall_in`.
  - HALT: PC and IF/ID frozen, `if_id_valid` = 0, all strobes 0. Left only by rst.

## Timing
- Reset values: `pc_curr`=RESET_PC, `if_id_pc`=0, `if_id_valid`=0, `if_id_pred_*`=0, `halted`=0, both counters 0, state BOOT.
- During and after reset, every combinational strobe is 0 because `if_id_valid`=0.
- Mispredict detected in cycle N:
  - N+1: `pc_curr`=`redirect_pc`, `if_id_valid`=0.
  - N+2: the correct-path instruction is in IF/ID.
  - Penalty is exactly 1 bubble.
- Correctly predicted taken branch: zero bubbles.
- `stall_in` and a mispredicted branch together: no resolution that cycle. The branch re-resolves on the first unstalled cycle; counters count it once.
- rst mid-RECOVER or mid-HALT: next cycle matches the reset values exactly.
- Update strobes are single-cycle. The predictor samples them at the same edge that advances the PC.

## Test plan
- Reset, then 4 unstalled cycles, `pred_taken`=0 → `pc_curr` 0,0,2,4,6; `if_id_valid` goes high in the 2nd cycle after reset.
- Branch at PC 0x0010 predicted not-taken, actual taken to 0x0400 → `branch_mispredicted`=1, `btb_wen`=1; next `pc_curr`=0x0400, `if_id_valid`=0; `mispred_cnt`=1.
- Predicted taken to 0x0200, actual not-taken, `if_id_pc`=0x0030 → redirect to 0x0032, `btb_wen`=0, `upd_taken`=0.
- Predicted taken to 0x0200, actual taken to 0x0300 → mispredict on target; redirect 0x0300, `btb_wen`=1.
- `stall_in` held 3 cycles with a mispredicting branch in IF/ID → PC and IF/ID frozen, `upd_en`=0; redirect happens on release; `branch_cnt` +1 only.
- PC 16'hFFFE, no prediction → wraps to 0; HLT at 0x0008 → `halted`=1, PC frozen 5 cycles; rst → `pc_curr`=0.

Source files
------------

// File: rtl/fetch_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_redirect_ctrl
//
// Fetch-stage controller. Owns the fetch PC and the IF/ID pipeline latch
// (PC, valid bit and the prediction that travelled with the instruction).
// Branches sitting in IF/ID are resolved against the latched prediction; a
// wrong direction or a wrong taken-target squashes the wrong-path slot,
// redirects fetch and trains the predictor.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   stall_in               hazard stall: hold PC and IF/ID
//   halt_in                decode sees HLT in the IF/ID slot
//   pred_taken/target      predictor output for pc_curr
//   id_is_branch           IF/ID instruction is a branch
//   id_actual_taken/target resolved branch outcome from decode
//   pc_curr                current fetch PC
//   if_id_*                IF/ID latch contents
//   branch_mispredicted    combinational misprediction strobe
//   flush_if_id            squash request for IF/ID (same as mispredict)
//   upd_en/upd_taken/upd_pc BHT training strobe, direction and index
//   btb_wen                BTB write strobe (data is id_actual_target)
//   halted                 controller is parked in HALT
//   branch_cnt/mispred_cnt saturating event counters
// -----------------------------------------------------------------------------
module fetch_redirect_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        halt_in,
  input  logic        pred_taken,
  input  logic [15:0] pred_target,
  input  logic        id_is_branch,
  input  logic        id_actual_taken,
  input  logic [15:0] id_actual_target,
  output logic [15:0] pc_curr,
  output logic [15:0] if_id_pc,
  output logic        if_id_valid,
  output logic        if_id_pred_taken,
  output logic [15:0] if_id_pred_target,
  output logic        branch_mispredicted,
  output logic        flush_if_id,
  output logic        upd_en,
  output logic        upd_taken,
  output logic [3:0]  upd_pc,
  output logic        btb_wen,
  output logic        halted,
  output logic [15:0] branch_cnt,
  output logic [15:0] mispred_cnt
);

  typedef enum logic [1:0] {
    ST_BOOT    = 2'd0,
    ST_RUN     = 2'd1,
    ST_RECOVER = 2'd2,
    ST_HALT    = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] if_id_pc_q, if_id_pc_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic        if_id_pred_taken_q, if_id_pred_taken_d;
  logic [15:0] if_id_pred_target_q, if_id_pred_target_d;
  logic [15:0] branch_cnt_q, branch_cnt_d;
  logic [15:0] mispred_cnt_q, mispred_cnt_d;

  logic        resolve;
  logic        dir_wrong;
  logic        target_wrong;
  logic        mispredict;
  logic        halt_take;
  logic [15:0] redirect_pc;
  logic [15:0] seq_pc;

  // ---------------------------------------------------------------------------
  // Branch resolution. A valid IF/ID slot only exists in RUN, so BOOT,
  // RECOVER and HALT naturally produce no resolution and no strobes.
  // ---------------------------------------------------------------------------
  always_comb begin
    resolve      = if_id_valid_q & id_is_branch & ~stall_in;
    dir_wrong    = if_id_pred_taken_q != id_actual_taken;
    // Direction agreed on "taken" but the BTB pointed somewhere else.
    target_wrong = if_id_pred_taken_q & id_actual_taken &
                   (if_id_pred_target_q != id_actual_target);
    mispredict   = resolve & (dir_wrong | target_wrong);
    // A branch in the same slot wins over an (illegal) simultaneous HLT.
    halt_take    = (state_q == ST_RUN) & if_id_valid_q & ~stall_in &
                   ~id_is_branch & halt_in;
    redirect_pc  = id_actual_taken ? id_actual_target : (if_id_pc_q + 16'd2);
    seq_pc       = pc_q + 16'd2;   // wraps mod 2^16 by width
  end

  // ---------------------------------------------------------------------------
  // Next-state, PC, IF/ID and counter logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (otherwise synthesis infers a latch).
    state_d             = state_q;
    pc_d                = pc_q;
    if_id_pc_d          = if_id_pc_q;
    if_id_valid_d       = if_id_valid_q;
    if_id_pred_taken_d  = if_id_pred_taken_q;
    if_id_pred_target_d = if_id_pred_target_q;
    branch_cnt_d        = branch_cnt_q;
    mispred_cnt_d       = mispred_cnt_q;

    unique case (state_q)
      ST_BOOT:    state_d = ST_RUN;
      ST_RUN: begin
        if (mispredict)     state_d = ST_RECOVER;
        else if (halt_take) state_d = ST_HALT;
      end
      ST_RECOVER: if (!stall_in) state_d = ST_RUN;
      ST_HALT:    state_d = ST_HALT;
      default:    state_d = ST_BOOT;
    endcase

    if (state_q == ST_HALT) begin
      // Frozen until reset; the slot is already invalid.
      if_id_valid_d = 1'b0;
    end else if (mispredict) begin
      // Squash the wrong-path instruction; the other IF/ID fields are don't-care.
      pc_d          = redirect_pc;
      if_id_valid_d = 1'b0;
    end else if (!stall_in) begin
      pc_d                = pred_taken ? pred_target : seq_pc;
      if_id_pc_d          = pc_q;
      if_id_pred_taken_d  = pred_taken;
      if_id_pred_target_d = pred_target;
      // The instruction fetched alongside an honored HLT is never executed.
      if_id_valid_d       = ~halt_take;
    end

    if (resolve && branch_cnt_q != 16'hFFFF)
      branch_cnt_d = branch_cnt_q + 16'd1;
    if (mispredict && mispred_cnt_q != 16'hFFFF)
      mispred_cnt_d = mispred_cnt_q + 16'd1;
  end

  // ---------------------------------------------------------------------------
  // State register (synchronous reset).
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q             <= ST_BOOT;
      pc_q                <= RESET_PC;
      if_id_pc_q          <= 16'h0000;
      if_id_valid_q       <= 1'b0;
      if_id_pred_taken_q  <= 1'b0;
      if_id_pred_target_q <= 16'h0000;
      branch_cnt_q        <= 16'h0000;
      mispred_cnt_q       <= 16'h0000;
    end else begin
      state_q             <= state_d;
      pc_q                <= pc_d;
      if_id_pc_q          <= if_id_pc_d;
      if_id_valid_q       <= if_id_valid_d;
      if_id_pred_taken_q  <= if_id_pred_taken_d;
      if_id_pred_target_q <= if_id_pred_target_d;
      branch_cnt_q        <= branch_cnt_d;
      mispred_cnt_q       <= mispred_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. Predictor strobes are single-cycle and sampled by the predictor
  // on the same edge that advances the PC.
  // ---------------------------------------------------------------------------
  assign pc_curr             = pc_q;
  assign if_id_pc            = if_id_pc_q;
  assign if_id_valid         = if_id_valid_q;
  assign if_id_pred_taken    = if_id_pred_taken_q;
  assign if_id_pred_target   = if_id_pred_target_q;
  assign branch_mispredicted = mispredict;
  assign flush_if_id         = mispredict;
  assign upd_en              = resolve;
  assign upd_taken           = id_actual_taken;
  assign upd_pc              = if_id_pc_q[3:0];
  assign btb_wen             = mispredict & id_actual_taken;
  assign halted              = (state_q == ST_HALT);
  assign branch_cnt          = branch_cnt_q;
  assign mispred_cnt         = mispred_cnt_q;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for fetch_redirect_ctrl. A driver applies directed and random
// stimulus each cycle and pushes the expected outputs computed by a
// behavioural model; an independent monitor pops and compares them.
// -----------------------------------------------------------------------------
module tb_fetch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_in, halt_in, pred_taken, id_is_branch, id_actual_taken;
  logic [15:0] pred_target, id_actual_target;
  logic [15:0] pc_curr, if_id_pc, if_id_pred_target, branch_cnt, mispred_cnt;
  logic        if_id_valid, if_id_pred_taken, branch_mispredicted, flush_if_id;
  logic        upd_en, upd_taken, btb_wen, halted;
  logic [3:0]  upd_pc;

  always #5 clk = ~clk;

  fetch_redirect_ctrl #(.RESET_PC(16'h0000)) dut (
    .clk                (clk),
    .rst                (rst),
    .stall_in           (stall_in),
    .halt_in            (halt_in),
    .pred_taken         (pred_taken),
    .pred_target        (pred_target),
    .id_is_branch       (id_is_branch),
    .id_actual_taken    (id_actual_taken),
    .id_actual_target   (id_actual_target),
    .pc_curr            (pc_curr),
    .if_id_pc           (if_id_pc),
    .if_id_valid        (if_id_valid),
    .if_id_pred_taken   (if_id_pred_taken),
    .if_id_pred_target  (if_id_pred_target),
    .branch_mispredicted(branch_mispredicted),
    .flush_if_id        (flush_if_id),
    .upd_en             (upd_en),
    .upd_taken          (upd_taken),
    .upd_pc             (upd_pc),
    .btb_wen            (btb_wen),
    .halted             (halted),
    .branch_cnt         (branch_cnt),
    .mispred_cnt        (mispred_cnt)
  );

  typedef struct {
    logic [15:0] pc, ifpc, ptg, bc, mc;
    logic        v, pt, mis, ue, ut, bw, h;
    logic [3:0]  up;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Behavioural model: pipeline contents as plain variables.
  logic        m_known = 1'b0;
  logic [15:0] m_pc, m_ifpc, m_ptg, m_bc, m_mc;
  logic        m_valid, m_pt, m_halted;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // One clock cycle: drive inputs, push expectations, advance the model.
  task automatic cyc(input logic r, input logic st, input logic hl,
                     input logic pt, input logic [15:0] ptg,
                     input logic br, input logic at, input logic [15:0] atg);
    exp_t e;
    logic res, mis, hh;
    @(negedge clk);
    rst = r; stall_in = st; halt_in = hl; pred_taken = pt; pred_target = ptg;
    id_is_branch = br; id_actual_taken = at; id_actual_target = atg;
    #1;
    res = m_valid & br & ~st;
    mis = res & ((m_pt != at) | (m_pt & at & (m_ptg != atg)));
    if (m_known) begin
      e.pc = m_pc; e.ifpc = m_ifpc; e.v = m_valid; e.pt = m_pt; e.ptg = m_ptg;
      e.mis = mis; e.ue = res; e.ut = at; e.up = m_ifpc[3:0];
      e.bw = mis & at; e.h = m_halted; e.bc = m_bc; e.mc = m_mc;
      exp_q.push_back(e);
    end
    if (r) begin
      m_known = 1'b1; m_pc = 16'h0000; m_ifpc = 16'h0000; m_valid = 1'b0;
      m_pt = 1'b0; m_ptg = 16'h0000; m_halted = 1'b0; m_bc = 16'h0000; m_mc = 16'h0000;
    end else if (!m_halted) begin
      if (res && m_bc != 16'hFFFF) m_bc = m_bc + 16'd1;
      if (mis && m_mc != 16'hFFFF) m_mc = m_mc + 16'd1;
      if (mis) begin
        m_pc    = at ? atg : m_ifpc + 16'd2;
        m_valid = 1'b0;
      end else if (!st) begin
        hh       = m_valid & hl & ~br;
        m_ifpc   = m_pc;
        m_pt     = pt;
        m_ptg    = ptg;
        m_valid  = ~hh;
        m_halted = hh;
        m_pc     = pt ? ptg : m_pc + 16'd2;
      end
    end
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
  endtask

  // Steer fetch to pc_val, fetch it with the given prediction; on return the
  // next cycle sees {pc_val, ptk, ptgt} valid in IF/ID.
  task automatic setup(input logic [15:0] pc_val, input logic ptk, input logic [15:0] ptgt);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, pc_val, 1'b0, 1'b0, 16'h0);
    cyc(1'b0, 1'b0, 1'b0, ptk, ptgt, 1'b0, 1'b0, 16'h0);
  endtask

  // Monitor: compares every cycle's outputs against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pc_curr",     pc_curr,             e.pc);
        check("if_id_pc",    if_id_pc,            e.ifpc);
        check("if_id_valid", {15'd0, if_id_valid}, {15'd0, e.v});
        check("if_id_pt",    {15'd0, if_id_pred_taken}, {15'd0, e.pt});
        check("if_id_ptg",   if_id_pred_target,   e.ptg);
        check("mispred",     {15'd0, branch_mispredicted}, {15'd0, e.mis});
        check("flush",       {15'd0, flush_if_id}, {15'd0, e.mis});
        check("upd_en",      {15'd0, upd_en},     {15'd0, e.ue});
        check("upd_taken",   {15'd0, upd_taken},  {15'd0, e.ut});
        check("upd_pc",      {12'd0, upd_pc},     {12'd0, e.up});
        check("btb_wen",     {15'd0, btb_wen},    {15'd0, e.bw});
        check("halted",      {15'd0, halted},     {15'd0, e.h});
        check("branch_cnt",  branch_cnt,          e.bc);
        check("mispred_cnt", mispred_cnt,         e.mc);
      end
    end
  end

  function automatic logic [15:0] pick_tgt();
    int k;
    k = $urandom_range(0, 4);
    return (k == 4) ? 16'hFFFE : 16'h0100 + 16'(2 * k);
  endfunction

  initial begin
    rst = 1'b1; stall_in = 1'b0; halt_in = 1'b0; pred_taken = 1'b0;
    pred_target = 16'h0; id_is_branch = 1'b0; id_actual_taken = 1'b0;
    id_actual_target = 16'h0;

    // Reset and sequential fetch.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    check("rst_pc", pc_curr, 16'h0000);
    check("rst_valid", {15'd0, if_id_valid}, 16'd0);
    idle(); check("boot_pc", pc_curr, 16'h0000);
    check("boot_valid", {15'd0, if_id_valid}, 16'd0);
    idle(); check("seq_pc2", pc_curr, 16'h0002);
    check("seq_valid", {15'd0, if_id_valid}, 16'd1);
    idle(); check("seq_pc4", pc_curr, 16'h0004);
    idle(); check("seq_pc6", pc_curr, 16'h0006);

    // Predicted not-taken, actually taken to 0x0400.
    setup(16'h0010, 1'b0, 16'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0400);
    check("tp2_mis", {15'd0, branch_mispredicted}, 16'd1);
    check("tp2_btb", {15'd0, btb_wen}, 16'd1);
    idle();
    check("tp2_pc", pc_curr, 16'h0400);
    check("tp2_valid", {15'd0, if_id_valid}, 16'd0);
    check("tp2_mcnt", mispred_cnt, 16'd1);

    // Predicted taken, actually not taken.
    setup(16'h0030, 1'b1, 16'h0200);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
    check("tp3_mis", {15'd0, branch_mispredicted}, 16'd1);
    check("tp3_btb", {15'd0, btb_wen}, 16'd0);
    check("tp3_ut", {15'd0, upd_taken}, 16'd0);
    idle(); check("tp3_pc", pc_curr, 16'h0032);

    // Taken both ways but wrong target.
    setup(16'h0030, 1'b1, 16'h0200);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0300);
    check("tp4_mis", {15'd0, branch_mispredicted}, 16'd1);
    check("tp4_btb", {15'd0, btb_wen}, 16'd1);
    idle(); check("tp4_pc", pc_curr, 16'h0300);

    // Stall over a mispredicting branch.
    setup(16'h0040, 1'b0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0500);
      check("tp5_upd_en", {15'd0, upd_en}, 16'd0);
      check("tp5_pc", pc_curr, 16'h0042);
      check("tp5_ifpc", if_id_pc, 16'h0040);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0500);
    check("tp5_mis", {15'd0, branch_mispredicted}, 16'd1);
    idle();
    check("tp5_pc_redir", pc_curr, 16'h0500);
    check("tp5_bcnt", branch_cnt, 16'd4);
    check("tp5_mcnt", mispred_cnt, 16'd4);

    // PC wrap, then HLT, then reset out of HALT.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 16'h0);
    idle(); check("wrap_pre", pc_curr, 16'hFFFE);
    idle(); check("wrap_post", pc_curr, 16'h0000);
    setup(16'h0008, 1'b0, 16'h0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    check("hlt_not_yet", {15'd0, halted}, 16'd0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'h0700, 1'b0, 1'b0, 16'h0);
      check("hlt_halted", {15'd0, halted}, 16'd1);
      check("hlt_pc", pc_curr, 16'h000C);
      check("hlt_valid", {15'd0, if_id_valid}, 16'd0);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    idle();
    check("hlt_rst_pc", pc_curr, 16'h0000);
    check("hlt_rst_halted", {15'd0, halted}, 16'd0);
    check("hlt_rst_bcnt", branch_cnt, 16'd0);

    // Random phase against the model.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 20,
          $urandom_range(0, 99) < 4, 1'($urandom_range(0, 1)), pick_tgt(),
          $urandom_range(0, 99) < 35, 1'($urandom_range(0, 1)), pick_tgt());
    end

    @(negedge clk);
    #5;
    check("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
